otter_fetch_queue: RTL

// - Instruction-fetch front end for the pipelined OTTER core. Sits between memory port 1 (MEM_ADDR1/MEM_READ1/MEM_DOUT1) and the decode stage.
// - Issues sequential fetches, tags each with its PC and buffers returned words in a DEPTH-entry FIFO.
// - Presents {IR, PC} to decode on a valid/ready handshake; a redirect from EX flushes the FIFO and restarts fetch at a new PC.

---
 rtl/otter_fetch_queue_if.sv | 37 +++
 rtl/otter_fetch_queue.sv | 116 +++++++++++
 2 files changed

// File: rtl/otter_fetch_queue_if.sv
// Fetch-queue bundle: memory port 1, decode handshake and redirect from EX.
// Carries EMPTY_CYCLES only when OTTER_FETCHQ_PERF_EN is defined.
interface otter_fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                     REDIRECT;
  logic [31:0]              REDIRECT_PC;
  logic [31:0]              MEM_ADDR1;
  logic                     MEM_READ1;
  logic [31:0]              MEM_DOUT1;
  logic                     DE_VALID;
  logic                     DE_READY;
  logic [31:0]              DE_IR;
  logic [31:0]              DE_PC;
  logic [$clog2(DEPTH):0]   Q_COUNT;
`ifdef OTTER_FETCHQ_PERF_EN
  logic [31:0]              EMPTY_CYCLES;

  modport master (
    input  REDIRECT, REDIRECT_PC, MEM_DOUT1, DE_READY,
    output MEM_ADDR1, MEM_READ1, DE_VALID, DE_IR, DE_PC, Q_COUNT, EMPTY_CYCLES
  );
  modport slave (
    output REDIRECT, REDIRECT_PC, MEM_DOUT1, DE_READY,
    input  MEM_ADDR1, MEM_READ1, DE_VALID, DE_IR, DE_PC, Q_COUNT, EMPTY_CYCLES
  );
`else
  modport master (
    input  REDIRECT, REDIRECT_PC, MEM_DOUT1, DE_READY,
    output MEM_ADDR1, MEM_READ1, DE_VALID, DE_IR, DE_PC, Q_COUNT
  );
  modport slave (
    output REDIRECT, REDIRECT_PC, MEM_DOUT1, DE_READY,
    input  MEM_ADDR1, MEM_READ1, DE_VALID, DE_IR, DE_PC, Q_COUNT
  );
`endif
endinterface

// File: rtl/otter_fetch_queue.sv
// OTTER instruction-fetch front end: credit-limited sequential fetch into a DEPTH-entry {IR, PC} FIFO.
// Optional empty-cycle counter when OTTER_FETCHQ_PERF_EN is defined.
module otter_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic               CLK,
  input logic               RESET,
  otter_fetch_queue_if.master bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int CW1 = CW + 1;

  logic [31:0]   fetch_pc, fetch_pc_nx;
  logic [31:0]   tag_pc, tag_pc_nx;
  logic [AW-1:0] head, head_nx;
  logic [AW-1:0] tail, tail_nx;
  logic [CW-1:0] count, count_nx;
  logic          inflight, inflight_nx;

  logic [31:0]   ir_mem [DEPTH];
  logic [31:0]   pc_mem [DEPTH];

  logic          de_valid;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW1-1:0] credit;

  assign de_valid = (count != '0);

  // Credit counts the in-flight word so a response always has a slot waiting for it.
  always_comb begin
    pop    = de_valid & bus.DE_READY & ~bus.REDIRECT;
    push   = inflight & ~bus.REDIRECT & ~RESET;
    credit = CW1'(count) + CW1'(inflight) - CW1'(pop);
    issue  = ~RESET & ~bus.REDIRECT & (credit < CW1'(DEPTH));
  end

  always_comb begin
    fetch_pc_nx = fetch_pc;
    tag_pc_nx   = tag_pc;
    head_nx     = head;
    tail_nx     = tail;
    count_nx    = count;
    inflight_nx = 1'b0;
    if (bus.REDIRECT) begin
      fetch_pc_nx = {bus.REDIRECT_PC[31:2], 2'b00};
      head_nx     = '0;
      tail_nx     = '0;
      count_nx    = '0;
    end else begin
      if (issue) begin
        fetch_pc_nx = fetch_pc + 32'd4;
        tag_pc_nx   = fetch_pc;
        inflight_nx = 1'b1;
      end
      if (pop)  head_nx = head + AW'(1);
      if (push) tail_nx = tail + AW'(1);
      count_nx = count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_pc <= RESET_PC;
      tag_pc   <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc_nx;
      tag_pc   <= tag_pc_nx;
      head     <= head_nx;
      tail     <= tail_nx;
      count    <= count_nx;
      inflight <= inflight_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      ir_mem[tail] <= bus.MEM_DOUT1;
      pc_mem[tail] <= tag_pc;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !pop) begin
      assert (count != CW'(DEPTH));
    end
  end

  assign bus.MEM_ADDR1 = fetch_pc;
  assign bus.MEM_READ1 = issue;
  assign bus.DE_VALID  = de_valid;
  assign bus.DE_IR     = de_valid ? ir_mem[head] : 32'h0;
  assign bus.DE_PC     = de_valid ? pc_mem[head] : 32'h0;
  assign bus.Q_COUNT   = count;

`ifdef OTTER_FETCHQ_PERF_EN
  logic [31:0] empty_cycles;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      empty_cycles <= '0;
    end else if (!de_valid && empty_cycles != 32'hFFFF_FFFF) begin
      empty_cycles <= empty_cycles + 32'd1;
    end
  end

  assign bus.EMPTY_CYCLES = empty_cycles;
`endif
endmodule
